// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the RV32I front end.
//   XLEN             : architectural register / address width
//   RESET_PC_DEFAULT : default PC of the first fetch after reset
//   NOP_INSN         : canonical RV32I NOP (addi x0, x0, 0)
//   S_BOOT/S_RUN/S_REDIR : fetch FSM state encodings
//   fetch_entry_t    : one fetch-buffer entry, {pc, instruction word}
// -----------------------------------------------------------------------------
package cpu_defs;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_REDIR = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with flush, occupancy count and a head that is read
// straight from storage (no combinational path from push to head).
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i         : write push_data_i this cycle
//   push_data_i    : entry to write
//   pop_i          : remove head this cycle (ignored when empty)
//   flush_i        : discard all entries; wins over push and pop
//   head_valid_o   : FIFO not empty
//   head_data_o    : oldest entry
//   count_o        : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic                     head_valid_o,
   output logic [WIDTH-1:0]         head_data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full, do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0) && !flush_i;
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = push_i && !flush_i && (!full || do_pop);

   always_comb begin
      // NOTE: every variable assigned here gets a default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (!do_push && do_pop) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_valid_o = (count_q != '0);
   assign head_data_o  = mem_q[rd_ptr_q];
   assign count_o      = count_q;

   // The fetch credit scheme guarantees space for every accepted response.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !flush_i && full && !do_pop));

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// RV32I fetch stage. Owns the PC, issues in-order word requests to instruction
// memory under a credit limit, buffers returned words with their PCs and hands
// one instruction per cycle to the decoder. Redirects flush the buffer and
// discard responses to requests issued before the redirect.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr : request channel (addr word aligned)
//   imem_rsp_valid/data : in-order response channel
//   redirect_valid/pc   : one-cycle redirect pulse and target
//   inst_valid/code/pc  : head of fetch buffer (NOP / 0 when not valid)
//   inst_ready          : decoder consumes head this cycle
//   fetch_misaligned    : sticky misaligned-redirect flag, present only when
//                         IFETCH_MISALIGN_CHECK_EN is defined
// Configuration macro: IFETCH_MISALIGN_CHECK_EN. Without it the low two bits
// of redirect_pc are ignored.
// -----------------------------------------------------------------------------
module instruction_fetch
   import cpu_defs::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_code,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
`ifdef IFETCH_MISALIGN_CHECK_EN
   ,
   output logic            fetch_misaligned
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   // Stale responses can pile up across back-to-back redirects, so the
   // in-flight counters get headroom beyond the buffer depth.
   localparam int OW = CW + 3;
   localparam int UW = OW + 1;
   localparam logic [OW-1:0] ONE_O   = OW'(1);
   localparam logic [UW-1:0] DEPTH_U = UW'(FIFO_DEPTH);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;          // next request address
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;  // PC of the next kept response
   logic [OW-1:0]   outst_q, outst_d;    // accepted, not yet answered
   logic [OW-1:0]   drop_q, drop_d;      // of those, how many are stale

   logic [CW-1:0]   fifo_count;
   logic            head_valid;
   fetch_entry_t    head_entry, push_entry;
   logic            push, pop, req_fire, blocked;
   logic [UW-1:0]   in_use;
   logic [XLEN-1:0] redir_target;

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic misaligned_q;

   assign redir_target = redirect_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              misaligned_q <= 1'b0;
      else if (redirect_valid) misaligned_q <= (redirect_pc[1:0] != 2'b00);
   end

   assign blocked          = misaligned_q;
   assign fetch_misaligned = misaligned_q;
`else
   assign redir_target = redirect_pc & ~XLEN'(3);
   assign blocked      = 1'b0;
`endif

   // Live work = requests still worth waiting for plus words already buffered.
   assign in_use = UW'(outst_q - drop_q) + UW'(fifo_count);

   assign imem_req_valid = (state_q == S_RUN) && (in_use < DEPTH_U)
                           && (outst_q != '1) && !blocked;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   always_comb begin
      // S_BOOT and S_REDIR each last one cycle; a redirect from any state wins.
      state_d  = redirect_valid ? S_REDIR : S_RUN;
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      outst_d  = outst_q;
      drop_d   = drop_q;
      push     = 1'b0;

      if (req_fire) pc_d = pc_q + XLEN'(4);

      if (req_fire && !imem_rsp_valid)      outst_d = outst_q + ONE_O;
      else if (!req_fire && imem_rsp_valid) outst_d = outst_q - ONE_O;

      if (imem_rsp_valid) begin
         if (drop_q != '0) begin
            drop_d = drop_q - ONE_O;
         end else begin
            push     = 1'b1;
            rsp_pc_d = rsp_pc_q + XLEN'(4);
         end
      end

      // Everything still in flight after this cycle, including a request
      // accepted right now, belongs to the old stream.
      if (redirect_valid) begin
         pc_d     = redir_target;
         rsp_pc_d = redir_target;
         drop_d   = outst_d;
         push     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_BOOT;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
      end
   end

   assign push_entry = '{pc: rsp_pc_q, data: imem_rsp_data};
   assign pop        = inst_valid && inst_ready;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .push_data_i  (push_entry),
      .pop_i        (pop),
      .flush_i      (redirect_valid),
      .head_valid_o (head_valid),
      .head_data_o  (head_entry),
      .count_o      (fifo_count)
   );

   assign inst_valid = head_valid && !blocked;
   assign inst_code  = inst_valid ? head_entry.data : NOP_INSN;
   // While blocked on a misaligned target, pc_q still holds that target.
   assign inst_pc    = blocked ? pc_q : (inst_valid ? head_entry.pc : '0);

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed scenarios followed by a randomized phase. A behavioural memory
// answers requests in order after a configurable latency; a stream model keeps
// the next PC the decoder should see, the next PC that should be requested and
// the next PC whose word has been delivered, and derives every expected output
// from those. Define IFETCH_MISALIGN_CHECK_EN to also exercise the
// misaligned-redirect option.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_fetch;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_code, inst_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif

   instruction_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_code      (inst_code),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
`ifdef IFETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      int          epoch;
      int          due;
   } req_t;

   req_t        pend[$];
   int          n_checks, n_fail;
   int          cyc_n, ok_at, epoch, n_acc;
   int          req_pct, inst_pct, lat_min, lat_max;
   logic [31:0] req_pc, exp_pc, dlv_pc, mis_pc;
   bit          mis;
   bit          redir_req;
   logic [31:0] redir_tgt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      pend.delete();
      cyc_n     = 0;
      ok_at     = 1;
      epoch++;
      n_acc     = 0;
      req_pc    = RPC;
      exp_pc    = RPC;
      dlv_pc    = RPC;
      mis       = 1'b0;
      mis_pc    = '0;
      redir_req = 1'b0;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step();
      int          live;
      bit          rv, iv, rsp;
      req_t        e;
      logic [31:0] tgt;

      live = int'((req_pc - exp_pc) >> 2);
      rv   = (cyc_n >= ok_at) && (live < DEPTH) && !mis;
      iv   = (dlv_pc != exp_pc);
      chk("req_valid", 32'(imem_req_valid), 32'(rv));
      if (imem_req_valid) chk("req_addr", imem_req_addr, req_pc);
      chk("inst_valid", 32'(inst_valid), 32'(iv));
      if (inst_valid) begin
         chk("inst_pc", inst_pc, exp_pc);
         chk("inst_code", inst_code, mem_word(exp_pc));
      end else begin
         chk("idle_code", inst_code, NOP_W);
         chk("idle_pc", inst_pc, mis ? mis_pc : 32'h0);
      end
`ifdef IFETCH_MISALIGN_CHECK_EN
      chk("misaligned", 32'(fetch_misaligned), 32'(mis));
`endif

      imem_req_ready = ($urandom_range(99) < req_pct);
      inst_ready     = ($urandom_range(99) < inst_pct);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      rsp            = 1'b0;
      e              = '0;
      if (pend.size() > 0 && pend[0].due <= cyc_n) begin
         e              = pend.pop_front();
         rsp            = 1'b1;
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(e.pc);
      end
      redirect_valid = redir_req;
      redirect_pc    = redir_req ? redir_tgt : 32'h0;

      if (imem_req_valid && imem_req_ready) begin
         pend.push_back('{pc: imem_req_addr, epoch: epoch,
                          due: cyc_n + int'($urandom_range(lat_max, lat_min))});
         req_pc = req_pc + 32'd4;
         n_acc++;
      end
      if (rsp && e.epoch == epoch) dlv_pc = dlv_pc + 32'd4;
      if (iv && inst_ready) exp_pc = exp_pc + 32'd4;
      if (redir_req) begin
         tgt = redir_tgt;
`ifdef IFETCH_MISALIGN_CHECK_EN
         mis    = (tgt[1:0] != 2'b00);
         mis_pc = tgt;
`else
         tgt[1:0] = 2'b00;
`endif
         epoch++;
         req_pc    = tgt;
         exp_pc    = tgt;
         dlv_pc    = tgt;
         ok_at     = cyc_n + 2;
         redir_req = 1'b0;
      end

      @(posedge clk);
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      epoch     = 0;
      req_pct   = 100;
      inst_pct  = 100;
      lat_min   = 1;
      lat_max   = 1;
      redir_req = 1'b0;
      redir_tgt = '0;

      // Reset state, then back-to-back fetch with a 1-cycle memory.
      do_reset();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_code", inst_code, NOP_W);
      chk("rst_inst_pc", inst_pc, 32'h0);
      step();
      chk("t1_valid_c1", 32'(imem_req_valid), 32'd1);
      chk("t1_addr_c1", imem_req_addr, 32'h0);
      step();
      chk("t1_addr_c2", imem_req_addr, 32'h4);
      step();
      chk("t1_addr_c3", imem_req_addr, 32'h8);
      chk("t1_inst_valid_c3", 32'(inst_valid), 32'd1);
      chk("t1_inst_pc_c3", inst_pc, 32'h0);
      run(8);

      // Decoder stalled: exactly DEPTH requests, then one per pop.
      do_reset();
      inst_pct = 0;
      run(8);
      chk("t2_accepts", 32'(n_acc), 32'd4);
      chk("t2_stalled", 32'(imem_req_valid), 32'd0);
      inst_pct = 100;
      step();
      inst_pct = 0;
      run(4);
      chk("t2_one_more", 32'(n_acc), 32'd5);
      inst_pct = 100;
      run(6);

      // Memory back-pressure: request held stable.
      do_reset();
      run(3);
      req_pct = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 32'(imem_req_valid), 32'd1);
         chk("t3_hold_addr", imem_req_addr, 32'h8);
         step();
      end
      req_pct = 100;
      run(6);

      // Redirect with two requests in flight on a 3-cycle memory.
      do_reset();
      lat_min = 3;
      lat_max = 3;
      run(3);
      req_pct   = 0;
      redir_req = 1'b1;
      redir_tgt = 32'h0000_0100;
      step();
      req_pct = 100;
      chk("t4_flush_valid", 32'(inst_valid), 32'd0);
      chk("t4_withdrawn", 32'(imem_req_valid), 32'd0);
      step();
      chk("t4_new_addr", imem_req_addr, 32'h0000_0100);
      for (int i = 0; i < 20 && !inst_valid; i++) step();
      chk("t4_first_valid", 32'(inst_valid), 32'd1);
      chk("t4_first_pc", inst_pc, 32'h0000_0100);
      step();
      chk("t4_second_pc", inst_pc, 32'h0000_0104);
      run(6);

      // Reset while the buffer holds three entries.
      do_reset();
      lat_min  = 1;
      lat_max  = 1;
      inst_pct = 0;
      run(5);
      chk("t5_head_pc", inst_pc, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("t5_rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("t5_rst_inst_code", inst_code, NOP_W);
      do_reset();
      inst_pct = 100;
      step();
      chk("t5_restart_addr", imem_req_addr, RPC);
      run(4);

      // PC wraps modulo 2^32.
      redir_req = 1'b1;
      redir_tgt = 32'hFFFF_FFF8;
      run(4);
      chk("t7_wrap_addr", imem_req_addr, 32'h0000_0000);
      run(8);

`ifdef IFETCH_MISALIGN_CHECK_EN
      // Misaligned redirect blocks fetch until an aligned one arrives.
      do_reset();
      run(4);
      redir_req = 1'b1;
      redir_tgt = 32'h0000_0102;
      run(4);
      chk("t6_flag", 32'(fetch_misaligned), 32'd1);
      chk("t6_no_req", 32'(imem_req_valid), 32'd0);
      chk("t6_inst_pc", inst_pc, 32'h0000_0102);
      redir_req = 1'b1;
      redir_tgt = 32'h0000_0200;
      step();
      chk("t6_cleared", 32'(fetch_misaligned), 32'd0);
      step();
      chk("t6_refetch", imem_req_addr, 32'h0000_0200);
      run(6);
`endif

      // Randomized traffic with random latencies, stalls and redirects.
      do_reset();
      req_pct  = 70;
      inst_pct = 70;
      lat_min  = 1;
      lat_max  = 4;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(99) < 4) begin
            redir_req = 1'b1;
            redir_tgt = $urandom;
            if ($urandom_range(3) != 0) redir_tgt[1:0] = 2'b00;
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
